ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the keyboard over the shared ps2_clk/ps2_data open-drain lines. It complements the existing PS/2 receive path (Ps2Controller) and sits beside it in the top level. While a transfer is in progress it tells the receiver to ignore the bus.

---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the open-drain ps2_clk/ps2_data lines.
// Optional build macro PS2_TX_RESEND_EN: on NACK or timeout the frame is retried once before reporting.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic               flt_q, flt_d;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               parity_q, parity_d;
    logic               data_oe_q, data_oe_d;
    logic               nack_q, nack_d;
    logic               err_q, err_d;
`ifdef PS2_TX_RESEND_EN
    logic               retry_q, retry_d;
`endif

    logic clk_s, data_s, fall, timeout, fail;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // The filtered clock only follows the synchronised line after FILTER_LEN identical samples.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        flt_d       = flt_q;
        flt_cnt_d   = '0;
        if (clk_s != flt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                flt_d = clk_s;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        fall = flt_q & ~flt_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        nack_d    = nack_q;
        err_d     = err_q;
        fail      = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shreg_d  = tx_data;
                    parity_d = ~^tx_data;
                    cnt_d    = '0;
                    state_d  = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                bitcnt_d = '0;
                cnt_d    = '0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q < 4'd8) begin
                        data_oe_d = ~shreg_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (timeout) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    nack_d  = data_s;
                    cnt_d   = '0;
                    state_d = S_WAIT_IDLE;
                end else if (timeout) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (flt_q && data_s) begin
                    if (nack_q) begin
                        fail = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end else if (fall) begin
                    cnt_d = '0;
                end else if (timeout) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            cnt_d     = '0;
            data_oe_d = 1'b0;
`ifdef PS2_TX_RESEND_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_INHIBIT;
            end else begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end
`else
            err_d   = 1'b1;
            state_d = S_DONE;
`endif
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
        if (reset) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            flt_q       <= 1'b1;
            flt_cnt_q   <= '0;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            nack_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            flt_q       <= flt_d;
            flt_cnt_q   <= flt_cnt_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            data_oe_q   <= data_oe_d;
            nack_q      <= nack_d;
            err_q       <= err_d;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign rx_inhibit  = (state_q != S_IDLE);
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = (state_q == S_DONE);
    assign tx_error    = (state_q == S_DONE) && err_q;

endmodule
